// File: rtl/ai_paddle_ctrl.sv
// Left-side pong opponent: after each physics step, scan five balls and register one paddle move code.
// Optional build macro AI_PREDICT_EN aims at posy + (vely <<< PRED_SHIFT) instead of posy.
module ai_paddle_ctrl #(
  parameter int HEIGHT          = 480,
  parameter int HALF_PAD_HEIGHT = 40,
  parameter int SPLIT_X         = 61,
  parameter int DEADBAND        = 4
`ifdef AI_PREDICT_EN
  ,
  parameter int PRED_SHIFT      = 2
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stclk,
  input  logic [54:0] ball_posx,
  input  logic [54:0] ball_posy,
  input  logic [54:0] ball_velx,
  input  logic [54:0] ball_vely,
  input  logic [10:0] paddle0_posy,
  input  logic [10:0] paddle1_posy,
  output logic [2:0]  ai_m,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  localparam logic signed [13:0] TGT_LO_C  = 14'(HALF_PAD_HEIGHT);
  localparam logic signed [13:0] TGT_HI_C  = 14'(HEIGHT - HALF_PAD_HEIGHT);
  localparam logic signed [13:0] TGT_MID_C = 14'(HEIGHT / 2);
  localparam logic signed [10:0] SPLIT_C   = 11'(SPLIT_X);
  localparam logic signed [11:0] DB_POS_C  = 12'(DEADBAND);
  localparam logic signed [11:0] DB_NEG_C  = 12'(-DEADBAND);

  state_t             state_r;
  logic [2:0]         idx_r;
  logic               best_valid_r;
  logic signed [10:0] best_x_r;
  logic signed [10:0] best_y_r;
  logic signed [10:0] best_vy_r;

  logic signed [10:0] sel_x_s;
  logic signed [10:0] sel_y_s;
  logic signed [10:0] sel_vy_s;
  logic               sel_left_s;
  logic signed [13:0] raw_tgt_s;
  logic signed [13:0] tgt_s;
  logic               use_p1_s;
  logic signed [10:0] pad_y_s;
  logic signed [11:0] err_s;
  logic [2:0]         move_s;

  // Only the direction bit of each x velocity matters; vely is dead without prediction.
  logic unused_bits_s;
`ifdef AI_PREDICT_EN
  assign unused_bits_s = ^{ball_velx[53:44], ball_velx[42:33], ball_velx[31:22],
                           ball_velx[20:11], ball_velx[9:0]};
`else
  assign unused_bits_s = ^{ball_velx[53:44], ball_velx[42:33], ball_velx[31:22],
                           ball_velx[20:11], ball_velx[9:0], ball_vely};
`endif

  // Select the lane of the ball currently being scanned.
  always_comb begin
    sel_x_s    = ball_posx[10:0];
    sel_y_s    = ball_posy[10:0];
    sel_vy_s   = ball_vely[10:0];
    sel_left_s = ball_velx[10];
    case (idx_r)
      3'd0: begin
        sel_x_s = ball_posx[10:0];  sel_y_s = ball_posy[10:0];
        sel_vy_s = ball_vely[10:0]; sel_left_s = ball_velx[10];
      end
      3'd1: begin
        sel_x_s = ball_posx[21:11];  sel_y_s = ball_posy[21:11];
        sel_vy_s = ball_vely[21:11]; sel_left_s = ball_velx[21];
      end
      3'd2: begin
        sel_x_s = ball_posx[32:22];  sel_y_s = ball_posy[32:22];
        sel_vy_s = ball_vely[32:22]; sel_left_s = ball_velx[32];
      end
      3'd3: begin
        sel_x_s = ball_posx[43:33];  sel_y_s = ball_posy[43:33];
        sel_vy_s = ball_vely[43:33]; sel_left_s = ball_velx[43];
      end
      3'd4: begin
        sel_x_s = ball_posx[54:44];  sel_y_s = ball_posy[54:44];
        sel_vy_s = ball_vely[54:44]; sel_left_s = ball_velx[54];
      end
      default: begin
        sel_x_s = ball_posx[10:0];  sel_y_s = ball_posy[10:0];
        sel_vy_s = ball_vely[10:0]; sel_left_s = ball_velx[10];
      end
    endcase
  end

  // Target, paddle choice and move code from the winning ball; 14-bit sum cannot wrap.
  always_comb begin
    raw_tgt_s = TGT_MID_C;
    if (best_valid_r) begin
`ifdef AI_PREDICT_EN
      raw_tgt_s = 14'(best_y_r) + (14'(best_vy_r) <<< PRED_SHIFT);
`else
      raw_tgt_s = 14'(best_y_r);
`endif
    end else begin
      raw_tgt_s = TGT_MID_C;
    end

    if (raw_tgt_s < TGT_LO_C) begin
      tgt_s = TGT_LO_C;
    end else if (raw_tgt_s > TGT_HI_C) begin
      tgt_s = TGT_HI_C;
    end else begin
      tgt_s = raw_tgt_s;
    end

    use_p1_s = !best_valid_r || (best_x_r > SPLIT_C);
    if (use_p1_s) begin
      pad_y_s = $signed(paddle1_posy);
    end else begin
      pad_y_s = $signed(paddle0_posy);
    end

    err_s = 12'(tgt_s) - 12'(pad_y_s);
    if (err_s > DB_POS_C) begin
      move_s = use_p1_s ? 3'd4 : 3'd2;
    end else if (err_s < DB_NEG_C) begin
      move_s = use_p1_s ? 3'd3 : 3'd1;
    end else begin
      move_s = 3'd0;
    end
  end

  // Scan sequencer with registered move code and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      idx_r        <= 3'd0;
      best_valid_r <= 1'b0;
      best_x_r     <= 11'sh3FF;
      best_y_r     <= 11'sd0;
      best_vy_r    <= 11'sd0;
      ai_m         <= 3'd0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          idx_r        <= 3'd0;
          best_valid_r <= 1'b0;
          best_x_r     <= 11'sh3FF;
          if (stclk) begin
            state_r <= ST_SCAN;
            busy    <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (stclk) begin
            overrun <= 1'b1;
          end
          // Strict less-than keeps the lower index on equal x.
          if (sel_left_s && (sel_x_s < best_x_r)) begin
            best_valid_r <= 1'b1;
            best_x_r     <= sel_x_s;
            best_y_r     <= sel_y_s;
            best_vy_r    <= sel_vy_s;
          end
          if (idx_r == 3'd4) begin
            state_r <= ST_DECIDE;
          end else begin
            idx_r <= idx_r + 3'd1;
          end
        end
        ST_DECIDE: begin
          if (stclk) begin
            overrun <= 1'b1;
          end
          ai_m    <= move_s;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ai_paddle_ctrl.sv
// Self-checking bench for ai_paddle_ctrl against a plain-arithmetic opponent model.
module tb_ai_paddle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stclk = 1'b0;
  logic [54:0] ball_posx = '0;
  logic [54:0] ball_posy = '0;
  logic [54:0] ball_velx = '0;
  logic [54:0] ball_vely = '0;
  logic [10:0] paddle0_posy = '0;
  logic [10:0] paddle1_posy = '0;
  logic [2:0]  ai_m;
  logic        busy;
  logic        overrun;

  int tests_run = 0;
  int tests_failed = 0;
  int px[5], py[5], vx[5], vy[5];
  int p0, p1;

  ai_paddle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .stclk(stclk),
    .ball_posx(ball_posx), .ball_posy(ball_posy),
    .ball_velx(ball_velx), .ball_vely(ball_vely),
    .paddle0_posy(paddle0_posy), .paddle1_posy(paddle1_posy),
    .ai_m(ai_m), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int model_move();
    int bx, by, bvy, tgt, err;
    bit found, use1;
    bx = 1023; by = 0; bvy = 0; found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (vx[i] < 0 && px[i] < bx) begin
        bx = px[i]; by = py[i]; bvy = vy[i]; found = 1'b1;
      end
    end
    if (!found) tgt = 240;
    else begin
      tgt = by;
`ifdef AI_PREDICT_EN
      tgt = by + bvy * 4;
`endif
    end
    if (tgt < 40) tgt = 40;
    if (tgt > 440) tgt = 440;
    use1 = !found || (bx > 61);
    err = tgt - (use1 ? p1 : p0);
    if (err > 4) return use1 ? 4 : 2;
    if (err < -4) return use1 ? 3 : 1;
    return 0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 5; i++) begin
      ball_posx[11*i +: 11] = 11'(px[i]);
      ball_posy[11*i +: 11] = 11'(py[i]);
      ball_velx[11*i +: 11] = 11'(vx[i]);
      ball_vely[11*i +: 11] = 11'(vy[i]);
    end
    paddle0_posy = 11'(p0);
    paddle1_posy = 11'(p1);
  endtask

  task automatic set_default_balls();
    for (int i = 0; i < 5; i++) begin
      px[i] = 300; py[i] = 240; vx[i] = 2; vy[i] = 0;
    end
    p0 = 240; p1 = 240;
  endtask

  // Pulse stclk (sampled at edge N), then verify busy, hold, latency and result.
  task automatic do_step(input int exp_m, input string name);
    int lat;
    logic [2:0] prev_m;
    prev_m = ai_m;
    lat = 0;
    @(posedge clk); #1;
    drive_inputs();
    stclk = 1'b1;
    @(posedge clk); #1;
    stclk = 1'b0;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s busy_start: got %b want 1", name, busy);
    end
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 5) begin
        tests_run++;
        if (ai_m !== prev_m) begin
          tests_failed++;
          $display("FAIL %s hold: got %0d want %0d", name, ai_m, prev_m);
        end
      end
      if (!busy) begin
        lat = n;
        break;
      end
    end
    tests_run++;
    if (lat != 6) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want 6", name, lat);
    end
    tests_run++;
    if (ai_m !== 3'(exp_m)) begin
      tests_failed++;
      $display("FAIL %s ai_m: got %0d want %0d", name, ai_m, exp_m);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ai_m !== 3'd0 || busy !== 1'b0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: got m=%0d b=%b o=%b want 0/0/0", ai_m, busy, overrun);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_candidate();
    set_default_balls();
    px[2] = 200; py[2] = 100; vx[2] = -3; p1 = 240;
    tests_run++;
    if (model_move() != 3) begin
      tests_failed++;
      $display("FAIL single_model: got %0d want 3", model_move());
    end
    do_step(3, "single_candidate");
  endtask

  task automatic test_tie();
    set_default_balls();
    px[1] = 50; py[1] = 400; vx[1] = -1;
    px[3] = 50; py[3] = 10;  vx[3] = -1;
    p0 = 240;
    do_step(2, "tie_lower_index");
  endtask

  task automatic test_no_candidate();
    set_default_balls();
    p1 = 243;
    do_step(0, "no_candidate_deadband");
    p1 = 250;
    do_step(3, "no_candidate_up");
  endtask

  task automatic test_predict_clamp();
    set_default_balls();
    px[0] = 300; py[0] = 430; vx[0] = -2; vy[0] = 5; p1 = 440;
`ifdef AI_PREDICT_EN
    do_step(0, "predict_clamp");
`else
    do_step(3, "predict_clamp");
`endif
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 5; i++) begin
        px[i] = int'($urandom_range(0, 800)) - 100;
        py[i] = int'($urandom_range(0, 580)) - 50;
        vx[i] = int'($urandom_range(0, 10)) - 5;
        vy[i] = int'($urandom_range(0, 120)) - 60;
      end
      if (t % 4 == 0) px[$urandom_range(0, 4)] = px[0];
      p0 = int'($urandom_range(0, 480));
      p1 = int'($urandom_range(0, 480));
      do_step(model_move(), "random");
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_quiet: got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun();
    int lat;
    int exp_m;
    set_default_balls();
    px[4] = 20; py[4] = 60; vx[4] = -4; p0 = 300;
    exp_m = model_move();
    lat = 0;
    @(posedge clk); #1;
    drive_inputs();
    stclk = 1'b1;
    @(posedge clk); #1;
    stclk = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      stclk = (n == 3) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      stclk = 1'b0;
      if (!busy) begin
        lat = n;
        break;
      end
    end
    tests_run++;
    if (lat != 6) begin
      tests_failed++;
      $display("FAIL overrun_latency: got %0d want 6", lat);
    end
    tests_run++;
    if (overrun !== 1'b1 || ai_m !== 3'(exp_m)) begin
      tests_failed++;
      $display("FAIL overrun_flag: got o=%b m=%0d want o=1 m=%0d", overrun, ai_m, exp_m);
    end
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_no_restart: got b=%b o=%b want b=0 o=1", busy, overrun);
    end
  endtask

  task automatic test_reset_midscan();
    set_default_balls();
    px[1] = 30; py[1] = 400; vx[1] = -1;
    @(posedge clk); #1;
    drive_inputs();
    stclk = 1'b1;
    @(posedge clk); #1;
    stclk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || ai_m !== 3'd0 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midscan: got b=%b m=%0d o=%b want 0/0/0", busy, ai_m, overrun);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    set_default_balls();
    p1 = 100;
    do_step(4, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single_candidate();
    test_tie();
    test_no_candidate();
    test_predict_clamp();
    test_random();
    test_overrun();
    test_reset_midscan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ai_paddle_ctrl.md
# ai_paddle_ctrl

Computer opponent for the left side of the pong game server. After every physics step it scans the five balls, picks the most threatening one, and issues a single registered move code `ai_m`. The code drives the physics step block's `AI_M` input, and that block applies it on the next `stclk`.

## Interface
- `HEIGHT`, 480: playfield height in pixels.
- `HALF_PAD_HEIGHT`, 40: clamp margin for target y.
- `SPLIT_X`, 61: x boundary. Balls with x > `SPLIT_X` are handled by paddle 1 (front); the rest by paddle 0 (back).
- `DEADBAND`, 4: |error| ≤ this produces no move.
- `PRED_SHIFT`, 2: velocity multiplier exponent used when prediction is compiled in.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `stclk` in 1: physics step strobe, one-cycle pulse.
- `ball_posx` in 55: five 11-bit signed x positions; ball i at [11i+10:11i].
- `ball_posy` in 55: five y positions, same packing.
- `ball_velx` in 55: five x velocities, same packing.
- `ball_vely` in 55: five y velocities, same packing.
- `paddle0_posy` in 11: back paddle centre y, signed.
- `paddle1_posy` in 11: front paddle centre y, signed.
- `ai_m` out 3: move code. 0 = none, 1 = p0 up, 2 = p0 down, 3 = p1 up, 4 = p1 down.
- `busy` out 1: a scan is in progress.
- `overrun` out 1: sticky; set when `stclk` arrives while `busy`.

## Operation
FSM states: IDLE, SCAN, DECIDE.
- **IDLE**
  - On `stclk`=1 go to SCAN.
  - Clear scan index to 0, best-valid to 0, best-x to 11'sh3FF.
- **SCAN**
  - One ball per cycle, index 0 to 4.
  - Ball i is a candidate when `velx[i][10]`=1 (moving left).
  - A candidate replaces the current best when posx < best-x, signed compare. Equal x keeps the lower index.
  - On index 4, go to DECIDE.
- **DECIDE**
  - Target y:
    - No candidate: `HEIGHT/2` = 240.
    - Candidate: best posy (see Configuration for prediction).
    - Clamp the target to [`HALF_PAD_HEIGHT`, `HEIGHT-HALF_PAD_HEIGHT`] = [40, 440].
  - Paddle select:
    - Paddle 1 if no candidate, or if best posx > `SPLIT_X`.
    - Otherwise paddle 0.
  - Error: err = target − paddle_y, 12-bit signed.
    - err > `DEADBAND`: down code (2 or 4).
    - err < −`DEADBAND`: up code (1 or 3).
    - Otherwise 0.
  - Register the result into `ai_m`, then go to IDLE.
- `ai_m` holds its value until the next DECIDE.
- Arithmetic:
  - Positions and velocities are 11-bit signed.
  - Prediction sum is computed in 14-bit signed before the clamp; no wrap-around is permitted.
- `stclk` while in SCAN or DECIDE:
  - The pulse is ignored; the scan is not restarted.
  - `overrun` is set to 1 and stays set until reset.

## Timing
- Reset values: state IDLE, `ai_m`=0, `busy`=0, `overrun`=0, scan index 0, best-valid 0.
- Reset asserted mid-scan aborts the scan; the same values apply on the next edge.
- Latency:
  - `stclk` sampled at edge N.
  - SCAN covers edges N+1 to N+5.
  - DECIDE registers `ai_m` at edge N+6.
- `busy`=1 from edge N+1 through N+6, and is 0 after edge N+6.
- Minimum `stclk` spacing is 8 cycles.
- Ball inputs change only on `stclk` edges, so they are stable during the scan. No internal snapshot is required.

## Configuration
- `AI_PREDICT_EN` defined:
  - Candidate target = posy + (vely <<< `PRED_SHIFT`), computed 14-bit signed, then clamped.
- Not defined:
  - Target = posy, then clamped.
  - `PRED_SHIFT` is unused.

## Test plan
- Reset with `stclk` idle → `ai_m`=0, `busy`=0, `overrun`=0.
- Ball 2 only candidate: posx=200, posy=100, velx=−3. Paddle1 y=240. → after 6 cycles `ai_m`=3. Balls 0,1,3,4 have velx=+2.
- Two candidates:
  - Ball 1 at x=50, y=400; ball 3 at x=50, y=10; both velx=−1. Paddle0 y=240.
  - → ball 1 wins the tie, `ai_m`=2.
- No candidates, paddle1 y=243 → err=−3 is inside the deadband, `ai_m`=0.
- `AI_PREDICT_EN`:
  - Ball posy=430, vely=+5, candidate posx=300. Raw target 450 clamps to 440.
  - Paddle1 y=440 → `ai_m`=0.
  - Without the macro: target 430, `ai_m`=3.
- `stclk` pulsed again 3 cycles into a scan → `overrun`=1, the scan completes at the original N+6, and no second scan starts.
